div_reconstruct: RTL and testbench

DIV_RECONSTRUCT -- requirements
Module: div_reconstruct

---
 rtl/div_pkg.sv | 19 +
 rtl/div_reconstruct_if.sv | 27 ++
 rtl/div_reconstruct.sv | 94 +++++++++
 tb/tb_div_reconstruct.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the reconstructing divider check block:
// state encoding, default operand width and accumulator sizing.
package div_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        DONE
    } state_t;

    // Q*Y needs 2W bits; one more bit holds the sign once R is added.
    function automatic int acc_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/div_reconstruct_if.sv
// Operand/result handshake bundle for div_reconstruct.
// The master side supplies operands and consumes the reconstructed dividend.
interface div_reconstruct_if import div_pkg::*; #(
    parameter int W = DEFAULT_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Q;
    logic [W-1:0] Y;
    logic [W:0]   R;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] X;
    logic         ovf;

    modport master (
        output in_valid, Q, Y, R, out_ready,
        input  in_ready, out_valid, X, ovf
    );

    modport slave (
        input  in_valid, Q, Y, R, out_ready,
        output in_ready, out_valid, X, ovf
    );

endinterface

// File: rtl/div_reconstruct.sv
// Rebuilds a dividend X = Q*Y + R from quotient, divisor and signed remainder
// using a serial shift-add multiply followed by one remainder add.
module div_reconstruct import div_pkg::*; #(
    parameter int W = DEFAULT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    div_reconstruct_if.slave bus
);

    localparam int AW = acc_width(W);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t        state;
    logic [W-1:0]  q_r;
    logic [W-1:0]  y_r;
    logic [W:0]    r_r;
    logic [AW-1:0] acc;
    logic [AW-1:0] partial;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  x_r;
    logic          ovf_r;

    // Partial product for the current quotient bit, and the final sum with R sign-extended.
    always_comb begin
        partial = '0;
        if (q_r[cnt]) begin
            partial = AW'(y_r) << cnt;
        end
        acc_sum = acc + {{(AW-W-1){r_r[W]}}, r_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_r         <= '0;
            y_r         <= '0;
            r_r         <= '0;
            acc         <= '0;
            cnt         <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            x_r         <= '0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        q_r        <= bus.Q;
                        y_r        <= bus.Y;
                        r_r        <= bus.R;
                        acc        <= '0;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc + partial;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W-1)) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    acc         <= acc_sum;
                    x_r         <= acc_sum[W-1:0];
                    ovf_r       <= |acc_sum[AW-1:W];
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    // Ready reasserts with the return to IDLE, so no back-to-back overlap is possible.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.X         = x_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_div_reconstruct.sv
// Self-checking bench for div_reconstruct: expected results are queued on
// operand accept and compared when the result handshake is about to occur.
module tb_div_reconstruct;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] x;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   check_count = 0;
    int   error_count = 0;

    always #5 clk = ~clk;

    div_reconstruct_if #(.W(W)) bus ();

    div_reconstruct #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] q, input logic [3:0] y, input logic [4:0] r);
        int   full;
        int   rv;
        exp_t e;
        rv    = r[4] ? int'(r) - 32 : int'(r);
        full  = int'(q) * int'(y) + rv;
        e.x   = full[3:0];
        e.ovf = (full < 0) || (full > 15);
        return e;
    endfunction

    // Scoreboard: a result handshake will happen on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            checkOutput("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_x", bus.X, e.x);
                checkOutput("sb_ovf", bus.ovf, e.ovf);
            end
        end
    end

    task automatic sendOperands(input logic [3:0] q, input logic [3:0] y, input logic [4:0] r);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("accept_ready", bus.in_ready, 1);
        bus.Q        = q;
        bus.Y        = y;
        bus.R        = r;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.Q        = 4'($urandom);
        bus.Y        = 4'($urandom);
        bus.R        = 5'($urandom);
    endtask

    task automatic applyStimulus(input logic [3:0] q, input logic [3:0] y, input logic [4:0] r, input int hold);
        exp_t e;
        int   lat;
        e = model(q, y, r);
        bus.out_ready = (hold == 0);
        exp_q.push_back(e);
        sendOperands(q, y, r);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 20);
        checkOutput("latency", lat, 5);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.Q        = 4'($urandom);
            bus.Y        = 4'($urandom);
            bus.R        = 5'($urandom);
            @(posedge clk);
            #1;
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_x", bus.X, e.x);
            checkOutput("hold_ovf", bus.ovf, e.ovf);
            checkOutput("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("valid_clear", bus.out_valid, 0);
        checkOutput("idle_ready", bus.in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic any_valid;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.Q         = '0;
        bus.Y         = '0;
        bus.R         = '0;
        bus.out_ready = 1'b0;
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_x", bus.X, 0);
        checkOutput("rst_ovf", bus.ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("pre_edge_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("first_edge_ready", bus.in_ready, 1);

        applyStimulus(4'd4,  4'd3,  5'b00000, 0);
        applyStimulus(4'd2,  4'd3,  5'b11111, 0);
        applyStimulus(4'd0,  4'd10, 5'b00101, 1);
        applyStimulus(4'd15, 4'd15, 5'b01111, 0);
        applyStimulus(4'd0,  4'd0,  5'b10000, 2);
        applyStimulus(4'd1,  4'd12, 5'b00001, 3);
        applyStimulus(4'd15, 4'd15, 5'b00101, 0);

        // Abort mid-multiply: outputs clear at once and the operation never completes.
        bus.out_ready = 1'b1;
        sendOperands(4'd5, 4'd7, 5'b00000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", bus.in_ready, 0);
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_x", bus.X, 0);
        checkOutput("abort_ovf", bus.ovf, 0);
        any_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_release_ready", bus.in_ready, 1);
        repeat (8) begin
            @(posedge clk);
            #1;
            any_valid = any_valid | bus.out_valid;
        end
        checkOutput("abort_no_valid", any_valid, 0);
        applyStimulus(4'd3, 4'd2, 5'b00000, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'($urandom), 4'($urandom), 5'($urandom), $urandom_range(0, 2));
        end

        checkOutput("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
